// File: rtl/pn_run_sequencer.sv
`timescale 1ns/1ps
// Load/step sequencer for the n-bit PN generator: fetches the polynomial, loads seed, strobes steps, captures states.
// Optional free-run prescaler is built when PN_AUTO_RUN_EN is defined.
module pn_run_sequencer #(
    parameter int WIDTH    = 13,
    parameter int SEL_W    = 4,
    parameter int ROM_LAT  = 1,
    parameter int SEED     = 2,
    parameter int CNT_W    = 16,
    parameter int AUTO_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] num,
    input  logic             next_pulse,
    input  logic             auto_mode,
    output logic [SEL_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic [WIDTH-1:0] poly,
    output logic [SEL_W-1:0] deg,
    output logic [WIDTH-1:0] seed,
    output logic             lfsr_load,
    output logic             lfsr_step,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic [WIDTH-1:0] disp_val,
    output logic [CNT_W-1:0] step_cnt,
    output logic             period_hit,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_CAPT  = 3'd3,
        S_READY = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0] MAX_DEG    = SEL_W'(WIDTH);
    localparam logic [1:0]       FETCH_LAST = 2'(ROM_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       fetch_cnt;
    logic             num_new;
    logic             num_ok;
    logic             step_req;
    logic [WIDTH-1:0] seed_mask;
    logic [WIDTH-1:0] seed_calc;
    logic             unused_in;

    assign num_new   = (num != deg);
    assign num_ok    = (num >= SEL_W'(2)) && (num <= MAX_DEG);
    assign unused_in = ^{rom_data, auto_mode};

    always_comb begin
        seed_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            seed_mask[i] = (i < int'(deg));
        end
        seed_calc = WIDTH'(SEED) & seed_mask;
        if (seed_calc == '0) begin
            seed_calc = WIDTH'(1);
        end
    end

`ifdef PN_AUTO_RUN_EN
    localparam int PRE_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_tick;

    assign pre_tick = auto_mode && (pre_cnt == PRE_W'(AUTO_DIV - 1));
    assign step_req = next_pulse | pre_tick;

    // The prescaler restarts whenever a new configuration is fetched.
    always_ff @(posedge clk) begin
        if (rst || !auto_mode || (state_next == S_FETCH && state != S_FETCH)) begin
            pre_cnt <= '0;
        end else if (pre_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_div;

    assign unused_div = AUTO_DIV;
    assign step_req   = next_pulse;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: if (fetch_cnt == FETCH_LAST) state_next = S_LOAD;
            S_LOAD:  state_next = S_CAPT;
            S_STEP:  state_next = S_CAPT;
            S_CAPT:  state_next = (lfsr_q == '0) ? S_LOAD : S_READY;
            S_READY: begin
                if (num_new) begin
                    if (num_ok) state_next = S_FETCH;
                end else if (step_req) begin
                    state_next = S_STEP;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            deg       <= MAX_DEG;
            poly      <= '0;
            seed      <= '0;
            disp_val  <= '0;
            step_cnt  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            fetch_cnt <= (state == S_FETCH && state_next == S_FETCH) ? fetch_cnt + 1'b1 : '0;
            unique case (state)
                S_FETCH: begin
                    if (state_next == S_LOAD) begin
                        poly <= rom_data[WIDTH-1:0];
                        seed <= seed_calc;
                    end
                end
                S_LOAD: step_cnt <= '0;
                S_STEP: if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
                S_CAPT: disp_val <= lfsr_q;
                S_READY: begin
                    if (num_new) begin
                        if (num_ok) begin
                            deg     <= num;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The address leads the FETCH state by one cycle so a registered ROM is already
    // presenting the new entry when FETCH begins.
    always_comb begin
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        period_hit = 1'b0;
        busy       = 1'b0;
        rom_addr   = deg;
        if (rst) begin
            rom_addr = MAX_DEG;
        end else begin
            busy = (state != S_READY);
            unique case (state)
                S_LOAD:  lfsr_load = 1'b1;
                S_STEP:  lfsr_step = 1'b1;
                S_CAPT:  period_hit = (lfsr_q == seed) && (step_cnt != '0);
                S_READY: if (num_new && num_ok) rom_addr = num;
                default: ;
            endcase
        end
    end

endmodule
